// File: rtl/hazard_unit_mc_pkg.sv
// Shared definitions for the multi-cycle hazard unit: forwarding mux
// select codes and the MUL/DIV occupancy state type.
package hazard_unit_mc_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline (master) drives the
// register addresses and control bits; the hazard unit (slave) returns
// forwarding selects, stall/flush controls and the stall-cycle counter.
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] Rs1D, Rs2D;
  logic [REG_AW-1:0] Rs1E, Rs2E;
  logic [REG_AW-1:0] RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              ResultSrcEb0;
  logic              PCSrcE;
  logic              MdValidE;

  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE;
  logic              FlushD, FlushE, FlushM;
  logic              MdDoneE;
  logic [PERF_W-1:0] StallCycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, MdValidE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MdDoneE, StallCycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, ResultSrcEb0, PCSrcE, MdValidE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MdDoneE, StallCycles
  );
endinterface

// File: rtl/hazard_unit_mc_md_busy_ctr.sv
// MUL/DIV occupancy tracker. Holds the instruction in E for MD_LATENCY
// cycles: stall for the first MD_LATENCY-1, flag done on the last.
//
//  state | meaning
//  IDLE  | no MUL/DIV in progress; a valid MUL/DIV here is its first E cycle
//  BUSY  | MUL/DIV in progress; cnt = remaining stall cycles, 0 = done cycle
module md_busy_ctr
  import hazard_unit_mc_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_valid,
  output logic md_stall,
  output logic md_done
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);
  localparam bit MULTI = (MD_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULTI ? MD_LATENCY - 2 : 0);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Occupancy FSM; the done cycle lives in BUSY so a new valid is ignored
  // there and the next MUL/DIV starts cleanly from IDLE on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_valid && MULTI) begin
            state <= BUSY;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != '0) cnt   <= cnt - CNT_W'(1);
          else           state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_stall = ((state == IDLE) && md_valid && MULTI) ||
                    ((state == BUSY) && (cnt != '0));
  assign md_done  = md_valid && !md_stall;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: E-stage forwarding (or a D-stage
// interlock when forwarding is disabled), load-use stall, branch flush,
// multi-cycle MUL/DIV hold and a saturating stall-cycle counter.
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FORWARD_EN = 1,
  parameter int MD_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hz
);

  localparam bit INTERLOCK = (FORWARD_EN == 0);

  logic              lw_stall, raw_stall;
  logic              md_stall, md_done;
  logic              md_hold, stall_any;
  logic [1:0]        fwd_a, fwd_b;
  logic [PERF_W-1:0] perf_q;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m, input logic wr_m,
    input logic [REG_AW-1:0] rd_w, input logic wr_w
  );
    if (wr_m && rd_m != '0 && rd_m == rs)      return FWD_MEM;
    else if (wr_w && rd_w != '0 && rd_w == rs) return FWD_WB;
    else                                       return FWD_RF;
  endfunction

  function automatic logic src_hit(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] rd, input logic wr
  );
    return wr && (src != '0) && (src == rd);
  endfunction

  md_busy_ctr #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk      (clk),
    .reset    (reset),
    .md_valid (hz.MdValidE),
    .md_stall (md_stall),
    .md_done  (md_done)
  );

  // Operand forwarding: M beats W; disabled entirely in interlock mode.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!INTERLOCK) begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    end
  end

  // Load-use and no-forwarding RAW detection; W needs no interlock because
  // the register file writes through.
  always_comb begin
    lw_stall  = hz.ResultSrcEb0 && (hz.RdE != '0) &&
                ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
    raw_stall = INTERLOCK &&
                (src_hit(hz.Rs1D, hz.RdE, hz.RegWriteE) ||
                 src_hit(hz.Rs1D, hz.RdM, hz.RegWriteM) ||
                 src_hit(hz.Rs2D, hz.RdE, hz.RegWriteE) ||
                 src_hit(hz.Rs2D, hz.RdM, hz.RegWriteM));
  end

  // Stalls are suppressed and every flush forced while in reset; E is
  // never flushed while it is being held by a MUL/DIV.
  always_comb begin
    md_hold   = !reset && md_stall;
    stall_any = !reset && (lw_stall || raw_stall || md_stall);
  end

  assign hz.ForwardAE   = fwd_a;
  assign hz.ForwardBE   = fwd_b;
  assign hz.StallF      = stall_any;
  assign hz.StallD      = stall_any;
  assign hz.StallE      = md_hold;
  assign hz.FlushM      = reset || md_hold;
  assign hz.FlushD      = reset || (hz.PCSrcE && !md_hold);
  assign hz.FlushE      = reset || ((lw_stall || raw_stall || hz.PCSrcE) && !md_hold);
  assign hz.MdDoneE     = md_done;
  assign hz.StallCycles = perf_q;

  // Saturating count of cycles in which fetch was stalled.
  always_ff @(posedge clk) begin
    if (reset)
      perf_q <= '0;
    else if (stall_any && (perf_q != {PERF_W{1'b1}}))
      perf_q <= perf_q + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: a forwarding DUT (defaults) and an interlock
// DUT (FORWARD_EN=0, PERF_W=4) share one stimulus stream and are checked
// every cycle against a positional behavioural model, plus directed scenarios.
module tb_hazard_unit_mc;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic rwe, rwm, rww, ld_e, pc_src, md;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // model state: position of current MUL/DIV within its E residency (-1 = none)
  int      mpos  = -1;
  longint  mperf1 = 0;
  longint  mperf2 = 0;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(32)) bus ();
  hazard_unit_mc_if #(.REG_AW(5), .PERF_W(4))  bus2 ();

  assign bus.Rs1D = rs1_d;  assign bus2.Rs1D = rs1_d;
  assign bus.Rs2D = rs2_d;  assign bus2.Rs2D = rs2_d;
  assign bus.Rs1E = rs1_e;  assign bus2.Rs1E = rs1_e;
  assign bus.Rs2E = rs2_e;  assign bus2.Rs2E = rs2_e;
  assign bus.RdE  = rd_e;   assign bus2.RdE  = rd_e;
  assign bus.RdM  = rd_m;   assign bus2.RdM  = rd_m;
  assign bus.RdW  = rd_w;   assign bus2.RdW  = rd_w;
  assign bus.RegWriteE = rwe;     assign bus2.RegWriteE = rwe;
  assign bus.RegWriteM = rwm;     assign bus2.RegWriteM = rwm;
  assign bus.RegWriteW = rww;     assign bus2.RegWriteW = rww;
  assign bus.ResultSrcEb0 = ld_e; assign bus2.ResultSrcEb0 = ld_e;
  assign bus.PCSrcE = pc_src;     assign bus2.PCSrcE = pc_src;
  assign bus.MdValidE = md;       assign bus2.MdValidE = md;

  hazard_unit_mc #(.REG_AW(5), .FORWARD_EN(1), .MD_LATENCY(LAT), .PERF_W(32)) dut (
    .clk(clk), .reset(rst), .hz(bus.slave));
  hazard_unit_mc #(.REG_AW(5), .FORWARD_EN(0), .MD_LATENCY(LAT), .PERF_W(4)) dut2 (
    .clk(clk), .reset(rst), .hz(bus2.slave));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] m_fwd(bit fe, logic [4:0] rs);
    if (!fe) return 2'b00;
    if (rwm && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rww && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_raw();
    bit r = 0;
    if (rs1_d != 0 && ((rwe && rs1_d == rd_e) || (rwm && rs1_d == rd_m))) r = 1;
    if (rs2_d != 0 && ((rwe && rs2_d == rd_e) || (rwm && rs2_d == rd_m))) r = 1;
    return r;
  endfunction

  function automatic bit m_lw();
    return ld_e && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
  endfunction

  function automatic int m_pos_eff();
    return (mpos < 0 && md) ? 0 : mpos;
  endfunction

  function automatic bit m_md();
    int p = m_pos_eff();
    return (p >= 0) && (p < LAT - 1);
  endfunction

  function automatic bit m_stall(bit fe);
    return !rst && (m_lw() || (!fe && m_raw()) || m_md());
  endfunction

  task automatic check_one(string tag, bit fe, longint perf_e,
                           logic [1:0] fa, logic [1:0] fb,
                           logic sf, logic sd, logic se,
                           logic fd, logic fle, logic fm, logic done,
                           logic [63:0] sc);
    bit s   = m_stall(fe);
    bit mdh = !rst && m_md();
    chk({tag, ".ForwardAE"}, 64'(fa), 64'(m_fwd(fe, rs1_e)));
    chk({tag, ".ForwardBE"}, 64'(fb), 64'(m_fwd(fe, rs2_e)));
    chk({tag, ".StallF"}, 64'(sf), 64'(s));
    chk({tag, ".StallD"}, 64'(sd), 64'(s));
    chk({tag, ".StallE"}, 64'(se), 64'(mdh));
    chk({tag, ".FlushM"}, 64'(fm), 64'(rst || mdh));
    chk({tag, ".FlushD"}, 64'(fd), 64'(rst || (pc_src && !mdh)));
    chk({tag, ".FlushE"}, 64'(fle),
        64'(rst || ((m_lw() || (!fe && m_raw()) || pc_src) && !mdh)));
    chk({tag, ".MdDoneE"}, 64'(done), 64'(md && !m_md()));
    chk({tag, ".StallCycles"}, sc, 64'(perf_e));
  endtask

  // per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check_one("fwd", 1'b1, mperf1, bus.ForwardAE, bus.ForwardBE, bus.StallF,
                bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM,
                bus.MdDoneE, 64'(bus.StallCycles));
      check_one("ilk", 1'b0, mperf2, bus2.ForwardAE, bus2.ForwardBE, bus2.StallF,
                bus2.StallD, bus2.StallE, bus2.FlushD, bus2.FlushE, bus2.FlushM,
                bus2.MdDoneE, 64'(bus2.StallCycles));
    end
  end

  // model state advance on each clock edge
  always @(posedge clk) begin
    if (rst) begin
      mpos   = -1;
      mperf1 = 0;
      mperf2 = 0;
    end else begin
      int p;
      if (m_stall(1'b1) && mperf1 < 64'hFFFF_FFFF) mperf1 = mperf1 + 1;
      if (m_stall(1'b0) && mperf2 < 15)            mperf2 = mperf2 + 1;
      p = m_pos_eff();
      if (p < 0 || p == LAT - 1) mpos = -1;
      else                       mpos = p + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0;
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    rwe = 0; rwm = 0; rww = 0; ld_e = 0; pc_src = 0; md = 0;
  endtask

  initial begin
    longint p0;
    idle();
    rst = 1;
    @(posedge clk); #1;
    chk_on = 1;
    @(negedge clk);
    chk("reset.StallCycles", 64'(bus.StallCycles), 64'd0);
    chk("reset.FlushD", 64'(bus.FlushD), 64'd1);
    chk("reset.FlushM", 64'(bus.FlushM), 64'd1);
    chk("reset.StallF", 64'(bus.StallF), 64'd0);
    step(); step();
    idle();

    // 1: forwarding priority
    step(); idle();
    rs1_e = 5; rd_m = 5; rwm = 1; rd_w = 5; rww = 1;
    @(negedge clk);
    chk("t1.mem", 64'(bus.ForwardAE), 64'b10);
    chk("t1.ilk_none", 64'(bus2.ForwardAE), 64'b00);
    step(); rwm = 0;
    @(negedge clk);
    chk("t1.wb", 64'(bus.ForwardAE), 64'b01);
    step(); rd_m = 0; rd_w = 0;
    @(negedge clk);
    chk("t1.rf", 64'(bus.ForwardAE), 64'b00);

    // 2: load-use
    step(); idle();
    ld_e = 1; rd_e = 7; rs2_d = 7;
    @(negedge clk);
    chk("t2.StallF", 64'(bus.StallF), 64'd1);
    chk("t2.StallD", 64'(bus.StallD), 64'd1);
    chk("t2.FlushE", 64'(bus.FlushE), 64'd1);
    step(); rd_e = 0;
    @(negedge clk);
    chk("t2.nostall", 64'(bus.StallF), 64'd0);

    // 3: single MUL/DIV
    step(); idle();
    md = 1;
    p0 = mperf1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk("t3.StallE", 64'(bus.StallE), (k < 3) ? 64'd1 : 64'd0);
      chk("t3.MdDoneE", 64'(bus.MdDoneE), (k == 3) ? 64'd1 : 64'd0);
    end
    chk("t3.cycles", 64'(bus.StallCycles), 64'(p0 + 3));

    // 4: back-to-back MUL/DIV
    step(); idle();
    step(); md = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk("t4.StallE", 64'(bus.StallE), ((k % 4) != 3) ? 64'd1 : 64'd0);
      chk("t4.MdDoneE", 64'(bus.MdDoneE), ((k % 4) == 3) ? 64'd1 : 64'd0);
    end

    // 5: branch with load-use, then reset mid-MUL/DIV
    step(); idle();
    ld_e = 1; rd_e = 7; rs1_d = 7; pc_src = 1;
    @(negedge clk);
    chk("t5.FlushD", 64'(bus.FlushD), 64'd1);
    chk("t5.FlushE", 64'(bus.FlushE), 64'd1);
    chk("t5.StallD", 64'(bus.StallD), 64'd1);
    step(); idle(); md = 1;
    step(); rst = 1;
    @(negedge clk);
    chk("t5.rst_StallE", 64'(bus.StallE), 64'd0);
    step(); rst = 0; md = 0;
    @(negedge clk);
    chk("t5.after_StallE", 64'(bus.StallE), 64'd0);
    chk("t5.after_StallF", 64'(bus.StallF), 64'd0);

    // 6: interlock mode and counter saturation
    step(); idle();
    rwe = 1; rd_e = 3; rs1_d = 3; rs1_e = 4; rd_m = 4; rwm = 1;
    @(negedge clk);
    chk("t6.StallD", 64'(bus2.StallD), 64'd1);
    chk("t6.FlushE", 64'(bus2.FlushE), 64'd1);
    chk("t6.ForwardAE", 64'(bus2.ForwardAE), 64'd0);
    chk("t6.fwd_dut_fwd", 64'(bus.ForwardAE), 64'b10);
    chk("t6.fwd_dut_nostall", 64'(bus.StallD), 64'd0);
    step(); idle();
    rwe = 1; rd_e = 3; rs1_d = 3;
    repeat (20) step();
    @(negedge clk);
    chk("t6.saturate", 64'(bus2.StallCycles), 64'd15);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      step();
      rst    = ($urandom_range(0, 63) == 0);
      rs1_d  = 5'($urandom_range(0, 7));
      rs2_d  = 5'($urandom_range(0, 7));
      rs1_e  = 5'($urandom_range(0, 7));
      rs2_e  = 5'($urandom_range(0, 7));
      rd_e   = 5'($urandom_range(0, 7));
      rd_m   = 5'($urandom_range(0, 7));
      rd_w   = 5'($urandom_range(0, 7));
      rwe    = 1'($urandom_range(0, 1));
      rwm    = 1'($urandom_range(0, 1));
      rww    = 1'($urandom_range(0, 1));
      ld_e   = ($urandom_range(0, 3) == 0);
      pc_src = ($urandom_range(0, 7) == 0);
      md     = ($urandom_range(0, 2) == 0);
    end

    step();
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
